// File: rtl/hdmi_timing_gen.sv
`default_nettype none
//==============================================================================
// Module : hdmi_timing_gen
// Desc   : 640x480 video timing generator with divided pixel enable and a
//          delayed display-enable/sync path matched to the readout pipeline.
// Rev    : 1.0  initial release
//==============================================================================
module hdmi_timing_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter int   CLK_DIV   = 5,
    parameter int   VDE_DELAY = 10,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        En,
    output logic        PixEn,
    output logic        HVsync,
    output logic        HMemRead,
    output logic        pVDE,
    output logic        Hsync,
    output logic        Vsync,
    output logic        FrameDone,
    output logic [15:0] FrameCnt
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL + 1);
    localparam int c_VW      = $clog2(c_V_TOTAL + 1);
    localparam int c_DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);
    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line entry: {display enable, hsync level, vsync level}
    localparam logic [2:0] c_DL_IDLE = {1'b0, ~SYNC_POL, ~SYNC_POL};

    logic [c_DW-1:0] r_div_cnt;
    logic            w_wrap;
    logic [c_HW-1:0] r_hcnt;
    logic [c_VW-1:0] r_vcnt;
    logic [c_HW-1:0] w_h_next;
    logic [c_VW-1:0] w_v_next;
    logic            w_hv_next;
    logic            w_mem_next;
    logic            w_hs_next;
    logic            w_vs_next;
    logic            w_frame_edge;

    logic            r_pix_en;
    logic            r_hv;
    logic            r_mem;
    logic            r_hs_raw;
    logic            r_vs_raw;
    logic            r_frame_done;
    logic [15:0]     r_frame_cnt;
    logic [2:0]      r_dl [VDE_DELAY];

    // Divider runs regardless of En so its phase tracks the receiver's divider
    assign w_wrap = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div_cnt <= '0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_comb begin
        w_h_next = r_hcnt;
        w_v_next = r_vcnt;
        if (r_hcnt == c_H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_vcnt == c_V_LAST) ? '0 : r_vcnt + 1'b1;
        end else begin
            w_h_next = r_hcnt + 1'b1;
        end
    end

    // Outputs decode the position that becomes current on this wrap edge
    assign w_hv_next    = (w_v_next < c_V_ACT);
    assign w_mem_next   = (w_h_next < c_H_ACT) && w_hv_next;
    assign w_hs_next    = ((w_h_next >= c_HS_BEG) && (w_h_next < c_HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign w_vs_next    = ((w_v_next >= c_VS_BEG) && (w_v_next < c_VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign w_frame_edge = (w_h_next == '0) && (w_v_next == c_V_ACT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hcnt       <= c_H_LAST;
            r_vcnt       <= c_V_LAST;
            r_pix_en     <= 1'b0;
            r_hv         <= 1'b0;
            r_mem        <= 1'b0;
            r_hs_raw     <= ~SYNC_POL;
            r_vs_raw     <= ~SYNC_POL;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_pix_en     <= w_wrap;
            r_frame_done <= 1'b0;
            if (!En) begin
                r_hcnt   <= c_H_LAST;
                r_vcnt   <= c_V_LAST;
                r_hv     <= 1'b0;
                r_mem    <= 1'b0;
                r_hs_raw <= ~SYNC_POL;
                r_vs_raw <= ~SYNC_POL;
            end else if (w_wrap) begin
                r_hcnt   <= w_h_next;
                r_vcnt   <= w_v_next;
                r_hv     <= w_hv_next;
                r_mem    <= w_mem_next;
                r_hs_raw <= w_hs_next;
                r_vs_raw <= w_vs_next;
                if (w_frame_edge) begin
                    r_frame_done <= 1'b1;
                    r_frame_cnt  <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    // Matches the memory readout plus colour-conversion latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < VDE_DELAY; i++) begin
                r_dl[i] <= c_DL_IDLE;
            end
        end else begin
            r_dl[0] <= {r_mem, r_hs_raw, r_vs_raw};
            for (int i = 1; i < VDE_DELAY; i++) begin
                r_dl[i] <= r_dl[i-1];
            end
        end
    end

    assign PixEn     = r_pix_en;
    assign HVsync    = r_hv;
    assign HMemRead  = r_mem;
    assign FrameDone = r_frame_done;
    assign FrameCnt  = r_frame_cnt;
    assign pVDE      = r_dl[VDE_DELAY-1][2];
    assign Hsync     = r_dl[VDE_DELAY-1][1];
    assign Vsync     = r_dl[VDE_DELAY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_hdmi_timing_gen.sv
`default_nettype none
//==============================================================================
// Module : tb_hdmi_timing_gen
// Desc   : Self-checking bench; two reduced-size instances (opposite sync
//          polarity, different delays) against a frame-position model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_hdmi_timing_gen;

    localparam int c_HA    = 8;
    localparam int c_HFP   = 2;
    localparam int c_HS    = 3;
    localparam int c_HBP   = 2;
    localparam int c_VA    = 6;
    localparam int c_VFP   = 1;
    localparam int c_VS    = 2;
    localparam int c_VBP   = 1;
    localparam int c_DIV   = 3;
    localparam int c_D0    = 4;
    localparam int c_D1    = 3;
    localparam int c_HT    = c_HA + c_HFP + c_HS + c_HBP;
    localparam int c_VT    = c_VA + c_VFP + c_VS + c_VBP;
    localparam int c_FRAME = c_HT * c_VT;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        r_en = 1'b0;

    logic        w0_pix, w0_hv, w0_mem, w0_pvde, w0_hs, w0_vs, w0_fd;
    logic [15:0] w0_fc;
    logic        w1_pix, w1_hv, w1_mem, w1_pvde, w1_hs, w1_vs, w1_fd;
    logic [15:0] w1_fc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hdmi_timing_gen #(
        .H_ACTIVE(c_HA), .H_FP(c_HFP), .H_SYNC(c_HS), .H_BP(c_HBP),
        .V_ACTIVE(c_VA), .V_FP(c_VFP), .V_SYNC(c_VS), .V_BP(c_VBP),
        .CLK_DIV(c_DIV), .VDE_DELAY(c_D0), .SYNC_POL(1'b0)
    ) dut0 (
        .clk(clk), .rstn(rstn), .En(r_en),
        .PixEn(w0_pix), .HVsync(w0_hv), .HMemRead(w0_mem), .pVDE(w0_pvde),
        .Hsync(w0_hs), .Vsync(w0_vs), .FrameDone(w0_fd), .FrameCnt(w0_fc)
    );

    hdmi_timing_gen #(
        .H_ACTIVE(c_HA), .H_FP(c_HFP), .H_SYNC(c_HS), .H_BP(c_HBP),
        .V_ACTIVE(c_VA), .V_FP(c_VFP), .V_SYNC(c_VS), .V_BP(c_VBP),
        .CLK_DIV(c_DIV), .VDE_DELAY(c_D1), .SYNC_POL(1'b1)
    ) dut1 (
        .clk(clk), .rstn(rstn), .En(r_en),
        .PixEn(w1_pix), .HVsync(w1_hv), .HMemRead(w1_mem), .pVDE(w1_pvde),
        .Hsync(w1_hs), .Vsync(w1_vs), .FrameDone(w1_fd), .FrameCnt(w1_fc)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 20)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: linear position within the frame plus a per-clock history of
    // undelayed active flags for the delayed outputs.
    int          m_div, m_pos, m_mc, m_h, m_v;
    bit          m_wrap, m_pix, m_hv, m_mem, m_hsa, m_vsa, m_fd;
    logic [15:0] m_fc;
    bit          h_mem [32];
    bit          h_hs  [32];
    bit          h_vs  [32];

    task automatic m_reset();
        m_div = 0; m_pos = c_FRAME - 1; m_mc = 0;
        m_pix = 0; m_hv = 0; m_mem = 0; m_hsa = 0; m_vsa = 0; m_fd = 0;
        m_fc = 16'd0;
        for (int i = 0; i < 32; i++) begin
            h_mem[i] = 0; h_hs[i] = 0; h_vs[i] = 0;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_reset();
            end else begin
                m_wrap = (m_div == c_DIV - 1);
                m_div  = m_wrap ? 0 : m_div + 1;
                m_pix  = m_wrap;
                m_fd   = 0;
                if (!r_en) begin
                    m_pos = c_FRAME - 1;
                    m_hv = 0; m_mem = 0; m_hsa = 0; m_vsa = 0;
                end else if (m_wrap) begin
                    m_pos = (m_pos + 1) % c_FRAME;
                    m_h   = m_pos % c_HT;
                    m_v   = m_pos / c_HT;
                    m_hv  = (m_v < c_VA);
                    m_mem = (m_h < c_HA) && (m_v < c_VA);
                    m_hsa = (m_h >= c_HA + c_HFP) && (m_h < c_HA + c_HFP + c_HS);
                    m_vsa = (m_v >= c_VA + c_VFP) && (m_v < c_VA + c_VFP + c_VS);
                    if (m_pos == c_VA * c_HT) begin
                        m_fd = 1;
                        m_fc = m_fc + 16'd1;
                    end
                end
                m_mc++;
                h_mem[m_mc % 32] = m_mem;
                h_hs[m_mc % 32]  = m_hsa;
                h_vs[m_mc % 32]  = m_vsa;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                chk("pixen0",  w0_pix,  m_pix);
                chk("hvsync0", w0_hv,   m_hv);
                chk("memrd0",  w0_mem,  m_mem);
                chk("fdone0",  w0_fd,   m_fd);
                chk("fcnt0",   w0_fc,   m_fc);
                chk("pvde0",   w0_pvde, h_mem[(m_mc + 32 - c_D0) % 32]);
                chk("hsync0",  w0_hs,   !h_hs[(m_mc + 32 - c_D0) % 32]);
                chk("vsync0",  w0_vs,   !h_vs[(m_mc + 32 - c_D0) % 32]);
                chk("pixen1",  w1_pix,  m_pix);
                chk("memrd1",  w1_mem,  m_mem);
                chk("fcnt1",   w1_fc,   m_fc);
                chk("pvde1",   w1_pvde, h_mem[(m_mc + 32 - c_D1) % 32]);
                chk("hsync1",  w1_hs,   h_hs[(m_mc + 32 - c_D1) % 32]);
                chk("vsync1",  w1_vs,   h_vs[(m_mc + 32 - c_D1) % 32]);
            end
        end
    end

    int n_mem, n_hs0, n_vs0;

    initial begin
        n_mem = 0; n_hs0 = 0; n_vs0 = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        r_en = 1'b1;

        // First frame from reset with hand-derived edge numbers
        for (int k = 1; k <= 460; k++) begin
            @(negedge clk);
            if (k <= 450) n_mem += int'(w0_mem);
            n_hs0 += int'(w0_hs == 1'b0);
            n_vs0 += int'(w0_vs == 1'b0);
            case (k)
                2:   chk("lit_pixen_pre", w0_pix, 16'd0);
                3:   begin
                         chk("lit_pixen_first", w0_pix, 16'd1);
                         chk("lit_mem_rise",    w0_mem, 16'd1);
                         chk("lit_hv_rise",     w0_hv,  16'd1);
                     end
                5:   chk("lit_pvde1_pre", w1_pvde, 16'd0);
                6:   begin
                         chk("lit_pvde1_rise", w1_pvde, 16'd1);
                         chk("lit_pvde0_pre",  w0_pvde, 16'd0);
                     end
                7:   chk("lit_pvde0_rise", w0_pvde, 16'd1);
                35:  chk("lit_hsync1_pre",  w1_hs, 16'd0);
                36:  chk("lit_hsync1_rise", w1_hs, 16'd1);
                272: begin
                         chk("lit_fd_pre",   w0_fd, 16'd0);
                         chk("lit_fcnt_pre", w0_fc, 16'd0);
                     end
                273: begin
                         chk("lit_fd_pulse", w0_fd, 16'd1);
                         chk("lit_fcnt_one", w0_fc, 16'd1);
                     end
                274: chk("lit_fd_post", w0_fd, 16'd0);
                452: chk("lit_mem_frame_end",  w0_mem, 16'd0);
                453: chk("lit_mem_frame2",     w0_mem, 16'd1);
                default: ;
            endcase
        end
        chk("lit_mem_clks_per_frame", 16'(n_mem), 16'd144);
        chk("lit_hsync_clks",         16'(n_hs0), 16'd90);
        chk("lit_vsync_clks",         16'(n_vs0), 16'd90);

        // Asynchronous reset in the middle of an active line
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("rst_pixen", w0_pix,  16'd0);
        chk("rst_hv",    w0_hv,   16'd0);
        chk("rst_mem",   w0_mem,  16'd0);
        chk("rst_pvde",  w0_pvde, 16'd0);
        chk("rst_hs0",   w0_hs,   16'd1);
        chk("rst_vs0",   w0_vs,   16'd1);
        chk("rst_hs1",   w1_hs,   16'd0);
        chk("rst_vs1",   w1_vs,   16'd0);
        chk("rst_fd",    w0_fd,   16'd0);
        chk("rst_fcnt",  w0_fc,   16'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) chk("restart_mem_pre",  w0_mem, 16'd0);
            if (k == 3) chk("restart_mem_rise", w0_mem, 16'd1);
            if (k == 7) chk("restart_pvde0",    w0_pvde, 16'd1);
        end

        // Randomised enable pattern, checked every cycle against the model
        for (int seg = 0; seg < 12; seg++) begin
            int unsigned hi;
            int unsigned lo;
            hi = $urandom_range(100, 1200);
            lo = $urandom_range(1, 30);
            r_en = 1'b1;
            repeat (hi) @(negedge clk);
            r_en = 1'b0;
            repeat (lo) @(negedge clk);
        end
        r_en = 1'b1;
        repeat (600) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
